// File: rtl/memory_stage.sv
// ============================================================================
// memory_stage : pipeline memory stage, handles loads/stores to a word-wide
//                data memory with a req/ack handshake and writeback stall.
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

package memory_stage_pkg;
  typedef logic [31:0] word_t;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  typedef struct packed {
    word_t       inst;
    word_t       pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        has_rs1;
    logic        has_rs2;
    logic        has_rd;
    word_t       imm;
    word_t       ex_result;
    logic        valid;
  } ex_mem_t;

  typedef struct packed {
    word_t       inst;
    word_t       pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        has_rd;
    word_t       result;
    logic        fault;
    logic        valid;
  } mem_wb_t;
endpackage

module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int ADDR_ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        wb_rdy,
  input  ex_mem_t     ex_mem,
  input  word_t       rs2_value,
  output logic        rdy,
  output mem_wb_t     mem_wb,
  output logic        dmem_req,
  output logic        dmem_we,
  output word_t       dmem_addr,
  output word_t       dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  word_t       dmem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, HOLD = 2'd2} state_t;

  state_t      state_q, state_d;
  mem_wb_t     mem_wb_q, mem_wb_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  word_t       dmem_addr_q, dmem_addr_d;
  word_t       dmem_wdata_q, dmem_wdata_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic [1:0]  off_q, off_d;
  word_t       rdata_q, rdata_d;

  logic        is_load, is_store, mem_op, funct3_ok, misaligned, bad, legal;
  logic [1:0]  off, eff_off;
  mem_wb_t     wb_cmp;

  function automatic word_t load_extract(word_t w, logic [2:0] f3, logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'b0, b};
      3'd5:    return {16'b0, h};
      default: return w;
    endcase
  endfunction

  always_comb begin
    is_load   = (ex_mem.opcode == OPCODE_LOAD);
    is_store  = (ex_mem.opcode == OPCODE_STORE);
    mem_op    = ex_mem.valid && (is_load || is_store);
    off       = ex_mem.ex_result[1:0];
    funct3_ok = is_load ? (ex_mem.funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                        : (ex_mem.funct3 < 3'd3);
    misaligned = (ADDR_ALIGN_CHECK != 0) &&
                 ((ex_mem.funct3[1:0] == 2'b01 && off[0]) ||
                  (ex_mem.funct3[1:0] == 2'b10 && off != 2'b00));
    bad       = mem_op && (!funct3_ok || misaligned);
    legal     = mem_op && !bad;
    // With alignment checking off, the low bits below the access size are masked.
    case (ex_mem.funct3[1:0])
      2'b01:   eff_off = {off[1], 1'b0};
      2'b10:   eff_off = 2'b00;
      default: eff_off = off;
    endcase

    wb_cmp.inst   = ex_mem.inst;
    wb_cmp.pc     = ex_mem.pc;
    wb_cmp.opcode = ex_mem.opcode;
    wb_cmp.funct3 = ex_mem.funct3;
    wb_cmp.rd     = ex_mem.rd;
    wb_cmp.has_rd = ex_mem.has_rd;
    wb_cmp.result = ex_mem.ex_result;
    wb_cmp.fault  = 1'b0;
    wb_cmp.valid  = ex_mem.valid;
  end

  always_comb begin
    state_d      = state_q;
    mem_wb_d     = mem_wb_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_be_d    = dmem_be_q;
    off_d        = off_q;
    rdata_d      = rdata_q;
    rdy          = 1'b0;

    case (state_q)
      IDLE: begin
        rdy = en && wb_rdy && !legal;
        if (en && legal) begin
          dmem_req_d  = 1'b1;
          dmem_we_d   = is_store;
          dmem_addr_d = {ex_mem.ex_result[31:2], 2'b00};
          off_d       = eff_off;
          case (ex_mem.funct3[1:0])
            2'b00: begin
              dmem_be_d    = 4'b0001 << eff_off;
              dmem_wdata_d = {4{rs2_value[7:0]}};
            end
            2'b01: begin
              dmem_be_d    = 4'b0011 << eff_off;
              dmem_wdata_d = {2{rs2_value[15:0]}};
            end
            default: begin
              dmem_be_d    = 4'b1111;
              dmem_wdata_d = rs2_value;
            end
          endcase
          state_d = ACCESS;
        end else if (rdy) begin
          mem_wb_d = wb_cmp;
          if (bad) begin
            mem_wb_d.result = '0;
            mem_wb_d.fault  = 1'b1;
            mem_wb_d.has_rd = 1'b0;
          end
        end
      end
      ACCESS: begin
        rdy = en && wb_rdy && dmem_ack;
        // An ack is always taken, even with en low: the memory side has
        // already completed, so the data is parked in HOLD rather than lost.
        if (dmem_ack) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          if (rdy) begin
            mem_wb_d        = wb_cmp;
            mem_wb_d.result = is_load ? load_extract(dmem_rdata, ex_mem.funct3, off_q) : '0;
            state_d         = IDLE;
          end else begin
            rdata_d = dmem_rdata;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        rdy = en && wb_rdy;
        if (rdy) begin
          mem_wb_d        = wb_cmp;
          mem_wb_d.result = is_load ? load_extract(rdata_q, ex_mem.funct3, off_q) : '0;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_wb_q     <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_be_q    <= '0;
      off_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      mem_wb_q     <= mem_wb_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_be_q    <= dmem_be_d;
      off_q        <= off_d;
      rdata_q      <= rdata_d;
    end
  end

  assign mem_wb     = mem_wb_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_be    = dmem_be_q;

endmodule

`default_nettype wire
